tmr_fault_monitor: RTL
======================

Name: tmr_fault_monitor

Overview:
- Registered stage directly downstream of the 3-way bitwise TMR voter.
- Per valid sample, takes the three replica words (data_1..data_3) and the voted word (tmr_out) and re-times the voted word.
- Detects which replica disagrees with the vote, keeps saturating per-replica error counters, and runs a persistence FSM.
- The FSM flags a replica as permanently faulty, or the triplet as degraded, for the scrubbing/reporting logic.

Parameters:
- WIDTH, 4: bit width of each replica and of the voted word.
- CNT_W, 8: width of each per-replica error counter.
- PERSIST, 3: consecutive single-replica mismatches on the same replica needed to declare it faulty (legal range 2..255).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- valid_in  in  1  sample on data_1..3/tmr_out is valid this cycle.
- data_1  in  WIDTH  replica 1.
- data_2  in  WIDTH  replica 2.
- data_3  in  WIDTH  replica 3.
- tmr_out  in  WIDTH  voted word from the voter.
- clear  in  1  synchronous clear of counters and FSM.
- valid_out  out  1  registered copy of valid_in.
- voted_q  out  WIDTH  tmr_out registered on valid_in.
- mism  out  3  per-replica mismatch flags of the last valid sample; bit k-1 corresponds to replica k.
- multi_mism  out  1  one-cycle pulse: two or more replicas mismatched in the last valid sample.
- err_cnt_1  out  CNT_W  mismatch count, replica 1.
- err_cnt_2  out  CNT_W  mismatch count, replica 2.
- err_cnt_3  out  CNT_W  mismatch count, replica 3.
- fault_id  out  2  suspect/faulty replica index: 1..3, or 0 for none.
- fault_valid  out  1  FSM is in FAULTY.
- degraded  out  1  FSM is in DEGRADED.
- vote_err  out  1  sticky internal re-vote mismatch (see Optional Feature).

Behaviour:
- One clock domain. Every output is registered.
- Reset (rst=1): every output = 0; FSM = OK; run counter = 0.
- rst overrides clear. clear has the same effect as rst on every output except that valid_out and voted_q still update normally.
- clear coinciding with valid_in: clear wins; the sample is not counted and does not affect the FSM.
- Latency: the sample presented at edge N is reflected in all outputs after edge N (1 cycle).
- valid_in=0: valid_out=0; mism and multi_mism drop to 0; voted_q, the counters and the FSM hold.
- mism[k-1] = (data_k != tmr_out), compared over the full word. Let nm = popcount(mism).
- Counters: err_cnt_k += 1 on each valid sample with mism[k-1]=1. Saturate at 2^CNT_W-1 with no wrap. Counters are independent of the FSM state.
- FSM states: OK, SUSPECT, FAULTY, DEGRADED. Internal run counter is 8 bits.
- OK:
  - nm=1 on replica k -> SUSPECT, fault_id=k, run=1.
  - nm>=2 -> DEGRADED.
  - nm=0 -> stay.
- SUSPECT(k):
  - nm=0 -> OK, fault_id=0, run=0.
  - nm=1 on k -> run+1; when run+1 == PERSIST -> FAULTY.
  - nm=1 on j != k -> SUSPECT(j), run=1.
  - nm>=2 -> DEGRADED.
- FAULTY(k): sticky; fault_id held.
  - nm>=2 -> DEGRADED.
  - Mismatch on any other single replica -> DEGRADED.
- DEGRADED: sticky until rst or clear. fault_id keeps its last value.
- multi_mism asserts for one cycle on every valid sample with nm>=2, in any state.
- Only valid samples advance the FSM; a gap (valid_in=0) does not break a run.

Optional Feature:
- Macro TMR_MON_CHECK_EN.
- Defined: the block computes its own bitwise majority of data_1..3 and compares it with tmr_out on each valid sample.
  - Any difference sets vote_err=1, sticky until rst or clear.
  - The comparison is registered with the same 1-cycle latency.
- Undefined: no check logic is built; vote_err is tied to 0.

Test Plan:
- Reset: assert rst for 2 cycles with random inputs -> every output 0, fault_id=0, FSM OK.
- Single transient: one valid sample 1111/1011/1111 with tmr_out=1111, then clean 1111/1111/1111 -> first: mism=010, err_cnt_2=1, fault_id=2; after the clean sample: fault_id=0, fault_valid=0.
- Persistent fault: three consecutive valid samples 1011/1001/1011 with tmr_out=1011 (PERSIST=3) -> fault_valid=1 and fault_id=2 after the third edge, err_cnt_2=3; a following clean sample keeps fault_valid=1.
- Multi-replica: 1010/1011/1111 with tmr_out=1011 -> mism=101, multi_mism one-cycle pulse, degraded=1, err_cnt_1=1, err_cnt_3=1; a later clean sample keeps degraded=1.
- Saturation/clear: CNT_W=2, five mismatches on replica 1 -> err_cnt_1=3. Then clear together with a mismatching valid sample -> all counters 0, FSM OK, sample not counted.
- With TMR_MON_CHECK_EN: data 1111/1111/1111 with tmr_out=0000 -> vote_err=1 next cycle and held until clear. Without the macro -> vote_err stays 0.

Source files
------------

// File: rtl/tmr_fault_monitor.sv
// tmr_fault_monitor: registered TMR vote checker with per-replica error counters and fault persistence FSM; TMR_MON_CHECK_EN adds an internal re-vote check.
module tmr_fault_monitor #(
  parameter int WIDTH   = 4,
  parameter int CNT_W   = 8,
  parameter int PERSIST = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] data_1,
  input  logic [WIDTH-1:0] data_2,
  input  logic [WIDTH-1:0] data_3,
  input  logic [WIDTH-1:0] tmr_out,
  input  logic             clear,
  output logic             valid_out,
  output logic [WIDTH-1:0] voted_q,
  output logic [2:0]       mism,
  output logic             multi_mism,
  output logic [CNT_W-1:0] err_cnt_1,
  output logic [CNT_W-1:0] err_cnt_2,
  output logic [CNT_W-1:0] err_cnt_3,
  output logic [1:0]       fault_id,
  output logic             fault_valid,
  output logic             degraded,
  output logic             vote_err
);
  typedef enum logic [1:0] {OK, SUSPECT, FAULTY, DEGRADED} state_t;
  localparam logic [7:0] PERSIST_W = 8'(PERSIST);
  state_t state_q, state_d;
  logic [7:0] run_q, run_d;
  logic [1:0] fid_d;
  logic [CNT_W-1:0] cnt_q [3];
  logic [2:0] m;
  logic multi, one;
  logic [1:0] id;
  assign m = {data_3 != tmr_out, data_2 != tmr_out, data_1 != tmr_out};
  assign multi = (m[0] & m[1]) | (m[0] & m[2]) | (m[1] & m[2]);
  assign one = |m & ~multi;
  assign id = m[0] ? 2'd1 : m[1] ? 2'd2 : 2'd3;
  assign err_cnt_1 = cnt_q[0];
  assign err_cnt_2 = cnt_q[1];
  assign err_cnt_3 = cnt_q[2];
  always_comb begin
    state_d = state_q;
    run_d = run_q;
    fid_d = fault_id;
    if (valid_in && multi) state_d = DEGRADED;
    else if (valid_in && one) begin
      case (state_q)
        OK: begin
          state_d = SUSPECT;
          fid_d = id;
          run_d = 8'd1;
        end
        SUSPECT: begin
          run_d = id == fault_id ? run_q + 8'd1 : 8'd1;
          fid_d = id;
          state_d = (id == fault_id && run_d == PERSIST_W) ? FAULTY : SUSPECT;
        end
        FAULTY: state_d = id == fault_id ? FAULTY : DEGRADED;
        default: state_d = DEGRADED;
      endcase
    end else if (valid_in && state_q == SUSPECT) begin
      state_d = OK;
      fid_d = 2'd0;
      run_d = 8'd0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out <= 1'b0;
      voted_q <= '0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) voted_q <= tmr_out;
    end
    if (rst || clear) begin
      state_q <= OK;
      run_q <= 8'd0;
      fault_id <= 2'd0;
      fault_valid <= 1'b0;
      degraded <= 1'b0;
      mism <= 3'b000;
      multi_mism <= 1'b0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      run_q <= run_d;
      fault_id <= fid_d;
      fault_valid <= state_d == FAULTY;
      degraded <= state_d == DEGRADED;
      mism <= valid_in ? m : 3'b000;
      multi_mism <= valid_in && multi;
      for (int i = 0; i < 3; i++)
        if (valid_in && m[i] && !(&cnt_q[i])) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
    end
  end
`ifdef TMR_MON_CHECK_EN
  logic [WIDTH-1:0] maj;
  assign maj = (data_1 & data_2) | (data_1 & data_3) | (data_2 & data_3);
  always_ff @(posedge clk)
    vote_err <= (rst || clear) ? 1'b0 : vote_err | (valid_in && maj != tmr_out);
`else
  assign vote_err = 1'b0;
`endif
endmodule
